// File: rtl/anim_pkg.sv
// Shared types and default timing constants for the LED animation timing path.
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } anim_state_e;

    localparam int ANIM_DIV_W     = 24;
    localparam int ANIM_STEP_DIV  = 12_500_000;
    localparam int ANIM_BLINK_DIV = 1_562_500;

    // Also the state width of the downstream bar-graph animation FSM.
    localparam int STEP_IDX_W = 4;

    function automatic bit div_legal(input int w, input int n, input int lo);
        if (w < 1 || w > 32) return 1'b0;
        return (n >= lo) && (64'(n) <= ((64'd1 << w) - 64'd1));
    endfunction

endpackage

// File: rtl/anim_divider.sv
// Modulo-N counter advancing while en_i is high, with a registered one-cycle tick.
module anim_divider
    import anim_pkg::*;
#(
    parameter int W = ANIM_DIV_W,
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic gate_i,
    output logic wrap_o,
    output logic tick_o
);

    if (!div_legal(W, N, 1)) begin : g_bad_div
        $fatal(1, "anim_divider: N out of range for width W");
    end

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;
    logic         pend_q, pend_d;

    assign wrap_o = en_i && (cnt_q == W'(N - 1));
    assign tick_o = tick_q;

    // A wrap that lands while the next cycle is not allowed to show a tick
    // is parked in pend_q and delivered on the first cycle gate_i reopens.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        pend_d = pend_q;
        if (clr_i) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (en_i) begin
                cnt_d = wrap_o ? '0 : cnt_q + W'(1);
            end
            tick_d = gate_i && (wrap_o || pend_q);
            pend_d = !gate_i && (wrap_o || pend_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/anim_tick_gen.sv
// Step/blink timing generator feeding the bar-graph animation FSM:
// ready step pulses, clk_out blink wave, run/hold control.
module anim_tick_gen
    import anim_pkg::*;
#(
    parameter int DIV_W     = ANIM_DIV_W,
    parameter int STEP_DIV  = ANIM_STEP_DIV,
    parameter int BLINK_DIV = ANIM_BLINK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    output logic                  ready,
    output logic                  clk_out,
    output logic                  running,
    output logic [STEP_IDX_W-1:0] step_idx
);

    if (!div_legal(DIV_W, STEP_DIV, 2)) begin : g_bad_step
        $fatal(1, "anim_tick_gen: STEP_DIV out of range");
    end
    if (!div_legal(DIV_W, BLINK_DIV, 1)) begin : g_bad_blink
        $fatal(1, "anim_tick_gen: BLINK_DIV out of range");
    end

    anim_state_e state_q, state_d;

    logic                  running_q, running_d;
    logic                  clk_out_q, clk_out_d;
    logic [STEP_IDX_W-1:0] step_idx_q, step_idx_d;

    logic div_clr, div_en, div_gate;
    logic step_wrap, blink_wrap;
    logic blink_tick_unused;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!stop && start) state_d = ARM;
            ARM:  state_d = stop ? IDLE : RUN;
            RUN: begin
                if (stop)       state_d = IDLE;
                else if (pause) state_d = HOLD;
            end
            HOLD: begin
                if (stop)        state_d = IDLE;
                else if (!pause) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Clearing on state_d==IDLE also kills a tick that would land in the
    // cycle after a stop.
    assign div_clr  = (state_q == IDLE) || (state_q == ARM) || (state_d == IDLE);
    assign div_en   = (state_q == RUN);
    assign div_gate = (state_d == RUN);

    anim_divider #(
        .W (DIV_W),
        .N (STEP_DIV)
    ) u_step (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (div_clr),
        .en_i   (div_en),
        .gate_i (div_gate),
        .wrap_o (step_wrap),
        .tick_o (ready)
    );

    anim_divider #(
        .W (DIV_W),
        .N (BLINK_DIV)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (div_clr),
        .en_i   (div_en),
        .gate_i (div_gate),
        .wrap_o (blink_wrap),
        .tick_o (blink_tick_unused)
    );

    always_comb begin
        running_d  = (state_d != IDLE);
        clk_out_d  = clk_out_q ^ blink_wrap;
        step_idx_d = step_idx_q;
        if ((state_d == IDLE) || (state_q == ARM)) begin
            clk_out_d = 1'b0;
        end
        if (state_q == ARM) begin
            step_idx_d = '0;
        end else if (step_wrap && (state_d != IDLE)) begin
            step_idx_d = step_idx_q + STEP_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q  <= 1'b0;
            clk_out_q  <= 1'b0;
            step_idx_q <= '0;
        end else begin
            running_q  <= running_d;
            clk_out_q  <= clk_out_d;
            step_idx_q <= step_idx_d;
        end
    end

    assign running  = running_q;
    assign clk_out  = clk_out_q;
    assign step_idx = step_idx_q;

endmodule
